vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator: hcount/vcount, syncs, blanking and frame-start strobe
// for the 1024x768 raster. Every output is registered on the same edge as the
// counters, so all flags describe the current hcount_out/vcount_out.
// Optional: define VGA_FRAME_CNT_EN to add a 16-bit frame counter (frame_cnt).
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE    = 1024,
    parameter int unsigned H_FP        = 24,
    parameter int unsigned H_SYNC      = 136,
    parameter int unsigned H_BP        = 160,
    parameter int unsigned V_ACTIVE    = 768,
    parameter int unsigned V_FP        = 3,
    parameter int unsigned V_SYNC      = 6,
    parameter int unsigned V_BP        = 29,
    parameter bit          SYNC_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    output logic [11:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned CW      = 12;
    localparam int unsigned FCW     = 16;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HB_START = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VB_START = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          h_wrap;
    logic          frame_wrap;
    logic          hblnk_next;
    logic          hsync_next;
    logic          vblnk_next;
    logic          vsync_next;

    // Next raster position and the decode of that position.
    always_comb begin
        h_wrap     = (hcount_out == H_LAST);
        frame_wrap = h_wrap && (vcount_out == V_LAST);
        h_next     = h_wrap ? '0 : hcount_out + CW'(1);
        v_next     = vcount_out;
        if (h_wrap) begin
            v_next = (vcount_out == V_LAST) ? '0 : vcount_out + CW'(1);
        end
        hblnk_next = (h_next >= HB_START);
        vblnk_next = (v_next >= VB_START);
        hsync_next = ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_next = ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // Timing registers: step on ce, hold otherwise; strobe always self-clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount_out  <= '0;
            vcount_out  <= '0;
            hblnk_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            hsync_out   <= ~SYNC_ACTIVE;
            vsync_out   <= ~SYNC_ACTIVE;
            frame_start <= 1'b0;
        end else if (ce) begin
            hcount_out  <= h_next;
            vcount_out  <= v_next;
            hblnk_out   <= hblnk_next;
            vblnk_out   <= vblnk_next;
            hsync_out   <= hsync_next;
            vsync_out   <= vsync_next;
            frame_start <= frame_wrap;
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter advances on the same edge that raises frame_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (ce && frame_wrap) begin
            frame_cnt <= frame_cnt + FCW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-timing instance (positive syncs) and
// one small-timing instance (negative syncs) so whole frames fit a short run.
// Expected values come from the count of ce edges since reset.
module tb_vga_timing_gen;

    localparam int unsigned DHA = 1024, DHF = 24, DHS = 136, DHB = 160;
    localparam int unsigned DVA = 768,  DVF = 3,  DVS = 6,   DVB = 29;
    localparam int unsigned SHA = 16,   SHF = 2,  SHS = 3,   SHB = 4;
    localparam int unsigned SVA = 6,    SVF = 1,  SVS = 2,   SVB = 2;
    localparam int unsigned DHT = DHA + DHF + DHS + DHB;
    localparam int unsigned DFT = DHT * (DVA + DVF + DVS + DVB);
    localparam int unsigned SFT = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;

    logic [11:0] hc_d, vc_d, hc_s, vc_s;
    logic        hsy_d, hbl_d, vsy_d, vbl_d, fs_d;
    logic        hsy_s, hbl_s, vsy_s, vbl_s, fs_s;
    logic [15:0] fc_d, fc_s;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    int unsigned nd = 0, ns = 0;
    bit          fsd_e = 1'b0, fss_e = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk(clk), .reset(reset), .ce(ce),
        .hcount_out(hc_d), .hsync_out(hsy_d), .hblnk_out(hbl_d),
        .vcount_out(vc_d), .vsync_out(vsy_d), .vblnk_out(vbl_d),
        .frame_start(fs_d)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_d)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .SYNC_ACTIVE(1'b0)
    ) dut_s (
        .clk(clk), .reset(reset), .ce(ce),
        .hcount_out(hc_s), .hsync_out(hsy_s), .hblnk_out(hbl_s),
        .vcount_out(vc_s), .vsync_out(vsy_s), .vblnk_out(vbl_s),
        .frame_start(fs_s)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_s)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign fc_d = 16'h0;
    assign fc_s = 16'h0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: position is the ce-edge count folded into the raster.
    task automatic check_inst(input string p, input int unsigned n, input bit fs_e,
                              input int unsigned ha, hf, hs, hb, va, vf, vs, vb,
                              input bit sa,
                              input logic [11:0] hc, input logic hsy, hbl,
                              input logic [11:0] vc, input logic vsy, vbl, fs,
                              input logic [15:0] fc);
        int unsigned ht, vt, h, v;
        bit hin, vin;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        h   = n % ht;
        v   = (n / ht) % vt;
        hin = (h >= ha + hf) && (h < ha + hf + hs);
        vin = (v >= va + vf) && (v < va + vf + vs);
        check({p, "_hcount"}, 32'(hc), h);
        check({p, "_vcount"}, 32'(vc), v);
        check({p, "_hblnk"},  32'(hbl), 32'(h >= ha));
        check({p, "_vblnk"},  32'(vbl), 32'(v >= va));
        check({p, "_hsync"},  32'(hsy), 32'(hin ? sa : !sa));
        check({p, "_vsync"},  32'(vsy), 32'(vin ? sa : !sa));
        check({p, "_frame_start"}, 32'(fs), 32'(fs_e));
`ifdef VGA_FRAME_CNT_EN
        check({p, "_frame_cnt"}, 32'(fc), (n / (ht * vt)) % 65536);
`else
        if (fc !== 16'h0) check({p, "_frame_cnt_tie"}, 32'(fc), 32'h0);
`endif
    endtask

    task automatic check_both();
        check_inst("d", nd, fsd_e, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1,
                   hc_d, hsy_d, hbl_d, vc_d, vsy_d, vbl_d, fs_d, fc_d);
        check_inst("s", ns, fss_e, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0,
                   hc_s, hsy_s, hbl_s, vc_s, vsy_s, vbl_s, fs_s, fc_s);
    endtask

    // One clock with the given ce, then compare both instances.
    task automatic cycle(input bit ce_v);
        @(negedge clk);
        ce = ce_v;
        @(posedge clk);
        #1;
        if (ce_v) begin
            nd++;
            ns++;
        end
        fsd_e = ce_v && (nd % DFT == 0);
        fss_e = ce_v && (ns % SFT == 0);
        check_both();
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge.
    task automatic do_reset(input bit ce_during);
        @(negedge clk);
        ce    = ce_during;
        reset = 1'b1;
        #1;
        nd = 0; ns = 0; fsd_e = 1'b0; fss_e = 1'b0;
        check_both();
        @(posedge clk);
        #1;
        check_both();
        @(negedge clk);
        ce    = 1'b0;
        reset = 1'b0;
    endtask

    initial begin : main
        int unsigned hsync_len;
        int unsigned hblnk_rise;
        int unsigned pulses;
        bit          seen;

        // Reset held with ce high.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_both();
        do_reset(1'b1);

        // First edge, then a full default line and a bit more.
        cycle(1'b1);
        check("first_edge_hcount", 32'(hc_d), 32'd1);
        hsync_len  = (hsy_d === 1'b1) ? 1 : 0;
        hblnk_rise = 0;
        seen       = 1'b0;
        for (int i = 0; i < int'(DHT) + 20; i++) begin
            cycle(1'b1);
            if (nd <= DHT && hsy_d === 1'b1) hsync_len++;
            if (!seen && hbl_d === 1'b1) begin
                seen       = 1'b1;
                hblnk_rise = 32'(hc_d);
            end
        end
        check("hsync_width", hsync_len, DHS);
        check("hblnk_rise_at", hblnk_rise, DHA);

        // Alternating ce across two small frames: counts hold, strobe stays one clk.
        pulses = 0;
        for (int i = 0; i < 4 * int'(SFT) + 8; i++) begin
            cycle(i % 2 == 0);
            if (fs_s === 1'b1) pulses++;
        end
        check("alt_ce_pulses", pulses, (ns / SFT) - ((ns - (2 * SFT + 4)) / SFT));

        // Random ce.
        for (int i = 0; i < 1200; i++) begin
            cycle($urandom_range(0, 3) != 0);
        end

        // Reset mid-frame, then three small frames.
        do_reset(1'b1);
        for (int i = 0; i < 3 * int'(SFT) + 5; i++) begin
            cycle(1'b1);
        end
`ifdef VGA_FRAME_CNT_EN
        check("frame_cnt_three", 32'(fc_s), 32'd3);
`endif
        do_reset(1'b0);
        cycle(1'b1);
        cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
